wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage directly downstream of the memory stage.
- Captures each instruction leaving MEM into a MEM/WB register and selects the result: ALU/address data, load data or atomic result.
- Drives the register-file write port, a forwarding bypass and the retired-instruction counter.
- Serialises trap commit to the CSR unit with a small handshake FSM that stalls and flushes the pipeline.

Parameters:
- XLEN, 64, datapath width
- REG_ADDR_W, 5, register index width
- CNT_W, 64, instret counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- mem_valid  in  1  MEM holds a real instruction (not a bubble)
- mem_stall  in  1  MEM stage stall output
- mem_rd  in  REG_ADDR_W  destination register
- mem_reg_write  in  1  instruction writes rd
- mem_wb_sel  in  2  result select: 0=ex_data, 1=mem_ex_rdata, 2=atomic_result, 3=reserved
- mem_pc  in  XLEN  instruction PC
- mem_ex_data  in  XLEN  ALU result / address
- mem_ex_rdata  in  XLEN  extended load data
- mem_atomic_result  in  XLEN  atomic return value
- mem_trap  in  1  trap (earlier-stage op_trapped or MEM gen_trap)
- mem_trap_cause  in  XLEN  mcause value
- mem_trap_val  in  XLEN  mtval value
- wb_stall  out  1  back-pressure to MEM and earlier stages
- mem_advance  out  1  = mem_valid & !mem_stall & !wb_stall
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_ADDR_W  write index
- rf_wdata  out  XLEN  write data
- byp_valid  out  1  WB holds a pending rd write (forwarding)
- byp_rd  out  REG_ADDR_W  bypass index
- byp_data  out  XLEN  bypass data
- trap_req  out  1  trap commit request to CSR
- trap_epc  out  XLEN  faulting PC
- trap_cause  out  XLEN  cause
- trap_tval  out  XLEN  tval
- trap_ack  in  1  CSR accepted trap and redirected fetch
- pipe_flush  out  1  flush all stages behind WB
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, reset==0):
  - State is RUN; the WB register is invalid.
  - All outputs are 0, including instret and the registered rf_wdata/trap fields.
- Capture:
  - On a rising edge with mem_advance=1, WB latches valid, rd, reg_write, the selected result, pc, trap, cause and val.
  - Result select happens at capture time; wb_sel=3 latches 0.
  - If mem_advance=0 in RUN, WB valid clears to 0 (bubble inserted).
- Commit latency: one cycle. An instruction captured at edge N drives rf_we during cycle N..N+1.
  - rf_we = wb_valid & reg_write & !trap & (rd != 0).
  - x0 writes are suppressed.
- Bypass:
  - byp_valid has the same condition as rf_we.
  - byp_rd/byp_data mirror rf_waddr/rf_wdata.
- instret: increments by 1 in each cycle WB holds a valid, non-trapping instruction. It wraps modulo 2^CNT_W.
- FSM:
  - RUN:
    - If wb_valid & trap: no rf write, no instret increment.
    - trap_req=1; trap_epc/cause/tval come from the WB register; wb_stall=1; next state is TRAP_WAIT.
  - TRAP_WAIT:
    - trap_req=1 and wb_stall=1; fields stay stable.
    - WB register is frozen (no capture).
    - On trap_ack=1, next state is FLUSH.
  - FLUSH:
    - For one cycle: pipe_flush=1, wb_stall=1, trap_req=0, wb_valid cleared.
    - Next state is RUN.
  - trap_req is high from the first cycle of a trap in RUN until the cycle trap_ack is sampled.
  - trap_ack in the RUN cycle where trap_req first rises is honoured: go directly to FLUSH.
  - trap_ack outside a trap_req cycle is ignored.
- wb_stall:
  - 0 in RUN when WB holds no trap; the stage never stalls for normal instructions.
  - wb_stall=1 forces mem_advance=0 even when MEM is ready.
- Back-to-back:
  - A new capture can occur in the same edge that commits the previous instruction.
  - The instruction following a trap is never captured (wb_stall) and is discarded by pipe_flush.
- Async reset mid-trap: FSM returns to RUN; trap_req and pipe_flush drop immediately.

Test Plan:
- Three back-to-back instructions (mem_valid=1, stall=0): sel0 rd=5 ex_data=0x11, sel1 rd=6 rdata=0x22, sel2 rd=7 atomic=0x33 -> rf_we on 3 consecutive cycles writing x5=0x11, x6=0x22, x7=0x33; instret=3.
- Write to rd=0 with ex_data=0xFFFF, reg_write=1 -> rf_we=0, byp_valid=0, instret increments to 1.
- mem_stall=1 for 4 cycles with mem_valid=1 -> mem_advance=0, rf_we=0, instret unchanged; after release, one commit.
- Load page fault: mem_trap=1, cause=13, val=0x8000_1000, pc=0x400 -> no rf write; trap_req=1 with epc=0x400, cause=13, tval=0x8000_1000.
  - Hold trap_ack=0 for 3 cycles: wb_stall=1, fields stable.
  - Assert trap_ack: next cycle pipe_flush=1 for exactly one cycle, then RUN; instret unchanged.
- trap_ack asserted in the same cycle trap_req first rises -> next cycle FLUSH; total stall 2 cycles.
- Deassert reset while in TRAP_WAIT -> trap_req=0, pipe_flush=0, instret=0 asynchronously.
  - After reset release, a normal instruction commits in 1 cycle.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, result select, register-file write,
// forwarding bypass, instret counter and trap-commit handshake FSM.
module wb_stage #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic                  mem_stall,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [1:0]            mem_wb_sel,
    input  logic [XLEN-1:0]       mem_pc,
    input  logic [XLEN-1:0]       mem_ex_data,
    input  logic [XLEN-1:0]       mem_ex_rdata,
    input  logic [XLEN-1:0]       mem_atomic_result,
    input  logic                  mem_trap,
    input  logic [XLEN-1:0]       mem_trap_cause,
    input  logic [XLEN-1:0]       mem_trap_val,
    output logic                  wb_stall,
    output logic                  mem_advance,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  byp_valid,
    output logic [REG_ADDR_W-1:0] byp_rd,
    output logic [XLEN-1:0]       byp_data,
    output logic                  trap_req,
    output logic [XLEN-1:0]       trap_epc,
    output logic [XLEN-1:0]       trap_cause,
    output logic [XLEN-1:0]       trap_tval,
    input  logic                  trap_ack,
    output logic                  pipe_flush,
    output logic [CNT_W-1:0]      instret
);

    localparam logic [1:0] RUN       = 2'd0;
    localparam logic [1:0] TRAP_WAIT = 2'd1;
    localparam logic [1:0] FLUSH     = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  valid_q, valid_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  rw_q, rw_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic [XLEN-1:0]       pc_q, pc_d;
    logic                  trap_q, trap_d;
    logic [XLEN-1:0]       cause_q, cause_d;
    logic [XLEN-1:0]       tval_q, tval_d;
    logic [CNT_W-1:0]      instret_q, instret_d;

    logic                  run_trap;
    logic                  commit;
    logic [XLEN-1:0]       sel_data;

    // Output decode from the WB register and FSM state
    always_comb begin
        run_trap    = (state_q == RUN) & valid_q & trap_q;
        trap_req    = run_trap | (state_q == TRAP_WAIT);
        pipe_flush  = (state_q == FLUSH);
        wb_stall    = trap_req | pipe_flush;
        mem_advance = mem_valid & ~mem_stall & ~wb_stall;
        commit      = valid_q & ~trap_q;
        rf_we       = commit & rw_q & (rd_q != '0);
        rf_waddr    = rd_q;
        rf_wdata    = data_q;
        byp_valid   = rf_we;
        byp_rd      = rd_q;
        byp_data    = data_q;
        trap_epc    = pc_q;
        trap_cause  = cause_q;
        trap_tval   = tval_q;
        instret     = instret_q;
    end

    // Result select at capture time; the reserved encoding yields zero
    always_comb begin
        sel_data = '0;
        case (mem_wb_sel)
            2'd0:    sel_data = mem_ex_data;
            2'd1:    sel_data = mem_ex_rdata;
            2'd2:    sel_data = mem_atomic_result;
            default: sel_data = '0;
        endcase
    end

    // Next-state: capture, bubble, trap hold and flush sequencing
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        rd_d      = rd_q;
        rw_d      = rw_q;
        data_d    = data_q;
        pc_d      = pc_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        tval_d    = tval_q;
        instret_d = commit ? instret_q + 1'b1 : instret_q;
        case (state_q)
            RUN: begin
                if (run_trap) begin
                    if (trap_ack) begin
                        state_d = FLUSH;
                        valid_d = 1'b0;
                    end else begin
                        state_d = TRAP_WAIT;
                    end
                end else if (mem_advance) begin
                    valid_d = 1'b1;
                    rd_d    = mem_rd;
                    rw_d    = mem_reg_write;
                    data_d  = sel_data;
                    pc_d    = mem_pc;
                    trap_d  = mem_trap;
                    cause_d = mem_trap_cause;
                    tval_d  = mem_trap_val;
                end else begin
                    valid_d = 1'b0;
                end
            end
            TRAP_WAIT: begin
                if (trap_ack) begin
                    state_d = FLUSH;
                    valid_d = 1'b0;
                end
            end
            FLUSH: begin
                state_d = RUN;
                valid_d = 1'b0;
            end
            default: begin
                state_d = RUN;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            valid_q   <= 1'b0;
            rd_q      <= '0;
            rw_q      <= 1'b0;
            data_q    <= '0;
            pc_q      <= '0;
            trap_q    <= 1'b0;
            cause_q   <= '0;
            tval_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            rd_q      <= rd_d;
            rw_q      <= rw_d;
            data_q    <= data_d;
            pc_q      <= pc_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
            tval_q    <= tval_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: table of directed vectors for the
// datapath plus hand-written trap handshake and reset sequences.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mem_stall, mem_reg_write, mem_trap, trap_ack;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [63:0] mem_pc, mem_ex_data, mem_ex_rdata, mem_atomic_result;
    logic [63:0] mem_trap_cause, mem_trap_val;
    logic        wb_stall, mem_advance, rf_we, byp_valid, trap_req, pipe_flush;
    logic [4:0]  rf_waddr, byp_rd;
    logic [63:0] rf_wdata, byp_data, trap_epc, trap_cause, trap_tval, instret;

    int n_run = 0;
    int n_fail = 0;

    wb_stage dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_stall(mem_stall),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_wb_sel(mem_wb_sel), .mem_pc(mem_pc),
        .mem_ex_data(mem_ex_data), .mem_ex_rdata(mem_ex_rdata),
        .mem_atomic_result(mem_atomic_result),
        .mem_trap(mem_trap), .mem_trap_cause(mem_trap_cause),
        .mem_trap_val(mem_trap_val),
        .wb_stall(wb_stall), .mem_advance(mem_advance),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
        .trap_req(trap_req), .trap_epc(trap_epc),
        .trap_cause(trap_cause), .trap_tval(trap_tval),
        .trap_ack(trap_ack), .pipe_flush(pipe_flush), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, stall, rw, ack;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [63:0] ex, rdata, atom;
        logic        e_we, e_adv;
        logic [4:0]  e_rd;
        logic [63:0] e_data, e_ret;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(
        input logic v, s, rw, ack, input logic [4:0] rd,
        input logic [1:0] sel, input logic [63:0] ex, rdata, atom,
        input logic e_we, e_adv, input logic [4:0] e_rd,
        input logic [63:0] e_data, e_ret);
        vec_t t;
        t.valid = v; t.stall = s; t.rw = rw; t.ack = ack;
        t.rd = rd; t.sel = sel; t.ex = ex; t.rdata = rdata; t.atom = atom;
        t.e_we = e_we; t.e_adv = e_adv; t.e_rd = e_rd;
        t.e_data = e_data; t.e_ret = e_ret;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, s, rw, input logic [4:0] rd,
                         input logic [1:0] sel,
                         input logic [63:0] ex, rdata, atom, pc,
                         input logic tr, input logic [63:0] cause, tval);
        mem_valid = v; mem_stall = s; mem_reg_write = rw; mem_rd = rd;
        mem_wb_sel = sel; mem_ex_data = ex; mem_ex_rdata = rdata;
        mem_atomic_result = atom; mem_pc = pc; mem_trap = tr;
        mem_trap_cause = cause; mem_trap_val = tval;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        trap_ack = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        tbl[0]  = mk(1,0,1,0, 5,0, 64'h11,   64'h0,  64'h0,  1,1, 5,64'h11, 0);
        tbl[1]  = mk(1,0,1,0, 6,1, 64'hAA,   64'h22, 64'h0,  1,1, 6,64'h22, 1);
        tbl[2]  = mk(1,0,1,0, 7,2, 64'hAA,   64'hBB, 64'h33, 1,1, 7,64'h33, 2);
        tbl[3]  = mk(1,0,1,0, 0,0, 64'hFFFF, 64'h0,  64'h0,  0,1, 0,64'h0,  3);
        tbl[4]  = mk(0,0,1,0, 1,0, 64'h1,    64'h0,  64'h0,  0,0, 0,64'h0,  4);
        for (int i = 5; i < 9; i++)
            tbl[i] = mk(1,1,1,0, 8,0, 64'h44, 64'h0, 64'h0, 0,0, 0,64'h0, 4);
        tbl[9]  = mk(1,0,1,0, 8,0, 64'h44,   64'h0,  64'h0,  1,1, 8,64'h44, 4);
        tbl[10] = mk(1,0,1,0, 9,3, 64'h55,   64'h56, 64'h57, 1,1, 9,64'h0,  5);
        tbl[11] = mk(1,0,0,1,10,0, 64'h66,   64'h0,  64'h0,  0,1, 0,64'h0,  6);
        tbl[12] = mk(0,0,0,0, 0,0, 64'h0,    64'h0,  64'h0,  0,0, 0,64'h0,  7);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_byp_valid", byp_valid, 0);
        chk("rst_trap_req", trap_req, 0);
        chk("rst_flush", pipe_flush, 0);
        chk("rst_stall", wb_stall, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_epc", trap_epc, 0);
        chk("rst_instret", instret, 0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].valid, tbl[i].stall, tbl[i].rw, tbl[i].rd,
                  tbl[i].sel, tbl[i].ex, tbl[i].rdata, tbl[i].atom,
                  64'(i * 4), 0, 0, 0);
            trap_ack = tbl[i].ack;
            tick();
            chk($sformatf("v%0d_rf_we", i), rf_we, tbl[i].e_we);
            chk($sformatf("v%0d_byp_valid", i), byp_valid, tbl[i].e_we);
            chk($sformatf("v%0d_adv", i), mem_advance, tbl[i].e_adv);
            chk($sformatf("v%0d_trap_req", i), trap_req, 0);
            chk($sformatf("v%0d_flush", i), pipe_flush, 0);
            chk($sformatf("v%0d_stall", i), wb_stall, 0);
            chk($sformatf("v%0d_instret", i), instret, tbl[i].e_ret);
            if (tbl[i].e_we) begin
                chk($sformatf("v%0d_waddr", i), rf_waddr, tbl[i].e_rd);
                chk($sformatf("v%0d_wdata", i), rf_wdata, tbl[i].e_data);
                chk($sformatf("v%0d_byp_rd", i), byp_rd, tbl[i].e_rd);
                chk($sformatf("v%0d_byp_data", i), byp_data, tbl[i].e_data);
            end
        end
        trap_ack = 1'b0;

        // Load page fault, acknowledged after a 3-cycle wait
        drive(1, 0, 1, 11, 0, 64'hDEAD, 0, 0, 64'h400,
              1, 64'd13, 64'h8000_1000);
        tick();
        chk("pf_trap_req", trap_req, 1);
        chk("pf_stall", wb_stall, 1);
        chk("pf_rf_we", rf_we, 0);
        chk("pf_byp_valid", byp_valid, 0);
        chk("pf_epc", trap_epc, 64'h400);
        chk("pf_cause", trap_cause, 64'd13);
        chk("pf_tval", trap_tval, 64'h8000_1000);
        drive(1, 0, 1, 12, 0, 64'h77, 0, 0, 64'h404, 0, 0, 0);
        #1;
        chk("pf_adv_blocked", mem_advance, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("pw%0d_trap_req", k), trap_req, 1);
            chk($sformatf("pw%0d_stall", k), wb_stall, 1);
            chk($sformatf("pw%0d_adv", k), mem_advance, 0);
            chk($sformatf("pw%0d_epc", k), trap_epc, 64'h400);
            chk($sformatf("pw%0d_cause", k), trap_cause, 64'd13);
            chk($sformatf("pw%0d_tval", k), trap_tval, 64'h8000_1000);
            chk($sformatf("pw%0d_flush", k), pipe_flush, 0);
            chk($sformatf("pw%0d_instret", k), instret, 7);
        end
        trap_ack = 1'b1;
        tick();
        chk("pf_flush", pipe_flush, 1);
        chk("pf_flush_stall", wb_stall, 1);
        chk("pf_flush_req", trap_req, 0);
        chk("pf_flush_rf_we", rf_we, 0);
        trap_ack = 1'b0;
        mem_valid = 1'b0;
        tick();
        chk("pf_run_flush", pipe_flush, 0);
        chk("pf_run_stall", wb_stall, 0);
        chk("pf_run_req", trap_req, 0);
        chk("pf_run_rf_we", rf_we, 0);
        chk("pf_run_instret", instret, 7);

        // Acknowledge in the very cycle the request rises
        drive(1, 0, 1, 14, 0, 64'h1, 0, 0, 64'h500, 1, 64'd2, 64'h1234);
        tick();
        chk("qa_trap_req", trap_req, 1);
        chk("qa_stall0", wb_stall, 1);
        chk("qa_epc", trap_epc, 64'h500);
        trap_ack = 1'b1;
        mem_trap = 1'b0;
        tick();
        chk("qa_flush", pipe_flush, 1);
        chk("qa_stall1", wb_stall, 1);
        chk("qa_req_low", trap_req, 0);
        trap_ack = 1'b0;
        mem_valid = 1'b0;
        tick();
        chk("qa_stall2", wb_stall, 0);
        chk("qa_flush_done", pipe_flush, 0);
        chk("qa_instret", instret, 7);

        // Asynchronous reset while waiting for acknowledge
        drive(1, 0, 1, 15, 0, 64'h2, 0, 0, 64'h600, 1, 64'd5, 64'h99);
        tick();
        mem_valid = 1'b0;
        tick();
        chk("ar_wait_req", trap_req, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_trap_req", trap_req, 0);
        chk("ar_flush", pipe_flush, 0);
        chk("ar_stall", wb_stall, 0);
        chk("ar_instret", instret, 0);
        #1;
        reset = 1'b1;
        drive(1, 0, 1, 13, 0, 64'h99, 0, 0, 64'h700, 0, 0, 0);
        tick();
        chk("ar_post_we", rf_we, 1);
        chk("ar_post_waddr", rf_waddr, 13);
        chk("ar_post_wdata", rf_wdata, 64'h99);
        chk("ar_post_instret0", instret, 0);
        mem_valid = 1'b0;
        tick();
        chk("ar_post_instret1", instret, 1);
        chk("ar_post_we_off", rf_we, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
